dmem_arbiter: RTL

- Two-requester arbiter in front of the 32-word single-port data memory.
- Requester 0 is the core load/store unit; requester 1 is the debug/DMA loader.
- Grants at most one access per cycle and drives the memory A/WD/WE.
- Captures RD into a per-requester response register, with round-robin fairness and a short atomic lock for read-modify-write.

---
 rtl/dmem_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-requester arbiter in front of a single-port, combinational-read data
// memory. Requester 0 is the core load/store unit, requester 1 the debug/DMA
// loader. At most one access is granted per cycle. The read data (the
// pre-write value for writes) is captured into a per-requester response
// register. Fairness is round-robin, and a short atomic lock supports
// read-modify-write sequences.
//
// Handshake: a request transfers on a cycle where req_valid[i] && req_ready[i].
// A response transfers on a cycle where rsp_valid[i] && rsp_ready[i]. req_ready
// is one-hot or zero. A requester is only eligible while its response slot is
// free or being drained, so each requester has at most one outstanding
// response.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   req_valid/ready/we/lock   per-requester request handshake ([0]=core, [1]=DMA)
//   req_addr0/1, req_wdata0/1 word address and write data per requester
//   rsp_valid/ready/err       per-requester response handshake, range error
//   rsp_rdata0/1              response read data (0 on range error)
//   mem_a/mem_wd/mem_we       memory address, write data, write enable
//   mem_rd                    memory combinational read data
//   grant_id                  last granted requester (debug)
module dmem_arbiter #(
  parameter int DEPTH    = 32,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [1:0]    req_we,
  input  logic [1:0]    req_lock,
  input  logic [AW-1:0] req_addr0,
  input  logic [AW-1:0] req_addr1,
  input  logic [DW-1:0] req_wdata0,
  input  logic [DW-1:0] req_wdata1,
  output logic [1:0]    rsp_valid,
  input  logic [1:0]    rsp_ready,
  output logic [DW-1:0] rsp_rdata0,
  output logic [DW-1:0] rsp_rdata1,
  output logic [1:0]    rsp_err,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd,
  output logic          grant_id
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCKED0 = 2'd1,
    LOCKED1 = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] lock_cnt, lock_cnt_nxt;
  logic          rr_ptr, rr_ptr_nxt;

  logic [1:0]    elig;
  logic [1:0]    gnt;
  logic          any_gnt;
  logic          win_id;
  logic          lock_id;
  logic          lock_live;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic          win_we;
  logic          win_oor;

  // A requester with an undrained response cannot issue again.
  assign elig = req_valid & (~rsp_valid | rsp_ready);

  // A lock whose owner has dropped req_valid is released in the same cycle,
  // so normal arbitration applies immediately.
  assign lock_id   = (state == LOCKED1);
  assign lock_live = (state != IDLE) && req_valid[lock_id];

  always_comb begin
    gnt = 2'b00;
    if (rst) begin
      if (lock_live) begin
        // The owner keeps the memory even while stalled on its response.
        if (elig[lock_id]) gnt = lock_id ? 2'b10 : 2'b01;
      end else if (&elig) begin
        gnt = rr_ptr ? 2'b10 : 2'b01;
      end else begin
        gnt = elig;
      end
    end
  end

  assign any_gnt   = |gnt;
  assign win_id    = gnt[1];
  assign win_addr  = win_id ? req_addr1 : req_addr0;
  assign win_wdata = win_id ? req_wdata1 : req_wdata0;
  assign win_we    = req_we[win_id];
  assign win_oor   = (win_addr >= AW'(DEPTH));

  assign req_ready = gnt;
  assign mem_a     = any_gnt ? win_addr : '0;
  assign mem_wd    = any_gnt ? win_wdata : '0;
  assign mem_we    = any_gnt && win_we && !win_oor;

  // Lock FSM and round-robin pointer.
  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    rr_ptr_nxt   = rr_ptr;
    if (lock_live) begin
      if (any_gnt) begin
        if (lock_cnt == CW'(MAX_LOCK - 1)) begin
          // Forced release: hand priority to the other requester.
          state_nxt    = IDLE;
          lock_cnt_nxt = '0;
          rr_ptr_nxt   = ~lock_id;
        end else if (!req_lock[lock_id]) begin
          state_nxt    = IDLE;
          lock_cnt_nxt = '0;
        end else begin
          lock_cnt_nxt = lock_cnt + CW'(1);
        end
      end
    end else begin
      state_nxt    = IDLE;
      lock_cnt_nxt = '0;
      if (any_gnt) begin
        rr_ptr_nxt = ~win_id;
        if (req_lock[win_id]) begin
          state_nxt    = win_id ? LOCKED1 : LOCKED0;
          lock_cnt_nxt = CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      lock_cnt   <= '0;
      rr_ptr     <= 1'b0;
      grant_id   <= 1'b0;
      rsp_valid  <= 2'b00;
      rsp_err    <= 2'b00;
      rsp_rdata0 <= '0;
      rsp_rdata1 <= '0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      rr_ptr   <= rr_ptr_nxt;
      if (any_gnt) grant_id <= win_id;

      // A new grant on the draining edge keeps the slot full with new data.
      if (gnt[0]) begin
        rsp_valid[0] <= 1'b1;
        rsp_err[0]   <= win_oor;
        rsp_rdata0   <= win_oor ? '0 : mem_rd;
      end else if (rsp_ready[0]) begin
        rsp_valid[0] <= 1'b0;
      end

      if (gnt[1]) begin
        rsp_valid[1] <= 1'b1;
        rsp_err[1]   <= win_oor;
        rsp_rdata1   <= win_oor ? '0 : mem_rd;
      end else if (rsp_ready[1]) begin
        rsp_valid[1] <= 1'b0;
      end
    end
  end

endmodule
